peripheral_mpram_wb_arbiter: RTL and testbench

Round-robin Wishbone B3 arbiter that lets `NUM_MASTERS` bus masters share the single Wishbone slave port of the single-port RAM (`peripheral_spram_wb`). It sits directly upstream of the RAM: each master port is a Wishbone slave interface, and the single downstream port is a Wishbone master interface wired to the RAM. A grant is held for the whole `cyc` period, so classic and incrementing-burst cycles pass through unbroken.

---
 rtl/peripheral_mpram_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_peripheral_mpram_wb_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_mpram_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS upstream masters share one RAM slave port.
// A grant is held for the whole cyc period; one IDLE cycle always separates two grants.
module peripheral_mpram_wb_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          last_q;    // most recent winner; equals the granted index while busy

    logic                   pick_vld;
    logic [IW-1:0]          pick_idx;
    logic [IW:0]            cand;
    int unsigned            gidx;

    // Round-robin search: first requester at last_q+1, last_q+2, ... wrapping modulo NUM_MASTERS.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, last_q} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(NUM_MASTERS)) begin
                cand = cand - (IW + 1)'(NUM_MASTERS);
            end
            if (!pick_vld && wbm_cyc_i[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    // Arbitration FSM; grant is released only after the owner drops cyc.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        grant_q <= NUM_MASTERS'(1) << pick_idx;
                        last_q  <= pick_idx;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!wbm_cyc_i[last_q]) begin
                        grant_q <= '0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Combinational request mux and response routing; everything is quiet while idle.
    always_comb begin
        gidx      = 32'(last_q);
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (state_q == StBusy) begin
            wbs_adr_o         = wbm_adr_i[gidx*AW +: AW];
            wbs_dat_o         = wbm_dat_i[gidx*DW +: DW];
            wbs_sel_o         = wbm_sel_i[gidx*SW +: SW];
            wbs_we_o          = wbm_we_i[last_q];
            wbs_cyc_o         = wbm_cyc_i[last_q];
            wbs_stb_o         = wbm_stb_i[last_q];
            wbs_cti_o         = wbm_cti_i[gidx*3 +: 3];
            wbs_bte_o         = wbm_bte_i[gidx*2 +: 2];
            wbm_ack_o[last_q] = wbs_ack_i;
            wbm_err_o[last_q] = wbs_err_i;
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_peripheral_mpram_wb_arbiter.sv
// Bench for peripheral_mpram_wb_arbiter: scripted/random master agents, a small RAM slave,
// and a per-cycle reference model of ownership plus a shadow-memory scoreboard.
module tb_peripheral_mpram_wb_arbiter;

    localparam int N = 3;
    localparam int QD = 64;
    localparam logic [31:0] ERR_ADR = 32'h0000_0EE0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          we;
        int          beats;
        int          gap;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*32-1:0] m_adr, m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [31:0]     dat_o;
    logic [N-1:0]    ack_o, err_o, grant;
    logic [31:0]     s_adr, s_dat;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic [31:0]     ram_rd;
    logic            ram_ack, ram_err;
    logic [31:0]     mem [0:255];

    int n_chk = 0;
    int n_bad = 0;

    // agents
    txn_t tq [N][QD];
    int   head [N];
    int   tail [N];
    bit   act [N];
    int   beat [N];
    int   wait_n [N];
    bit   jitter;

    // model and logs
    int          owner, lastm, ncyc;
    logic [N-1:0] cyc_s, ack_s, err_s, pcyc, pgrant;
    logic        rst_s;
    logic [31:0] shadow [0:255];
    bit          sh_vld [0:255];
    int          g_order [64];
    int          g_time [64];
    int          g_n, gfall;
    int          first_rise [N];
    int          first_drop [N];
    int          acks [N];
    logic [31:0] rdata_last [N];
    logic [N-1:0] err_seen, ack_at_err;

    always #5 clk = ~clk;

    peripheral_mpram_wb_arbiter #(.NUM_MASTERS(N), .AW(32), .DW(32)) dut (
        .wb_clk_i (clk),     .wb_rst_i (rst),
        .wbm_adr_i(m_adr),   .wbm_dat_i(m_dat),   .wbm_sel_i(m_sel),  .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc),   .wbm_stb_i(m_stb),   .wbm_cti_i(m_cti),  .wbm_bte_i(m_bte),
        .wbm_dat_o(dat_o),   .wbm_ack_o(ack_o),   .wbm_err_o(err_o),
        .wbs_adr_o(s_adr),   .wbs_dat_o(s_dat),   .wbs_sel_o(s_sel),  .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc),   .wbs_stb_o(s_stb),   .wbs_cti_o(s_cti),  .wbs_bte_o(s_bte),
        .wbs_dat_i(ram_rd),  .wbs_ack_i(ram_ack), .wbs_err_i(ram_err),
        .grant_o  (grant)
    );

    // RAM slave: one wait state per beat, error on a magic address.
    always @(posedge clk) begin
        if (rst) begin
            ram_ack <= 1'b0;
            ram_err <= 1'b0;
        end else if (s_cyc && s_stb && !ram_ack && !ram_err) begin
            if (s_adr == ERR_ADR) begin
                ram_err <= 1'b1;
            end else begin
                ram_ack <= 1'b1;
                if (s_we) mem[s_adr[9:2]] <= s_dat;
                ram_rd <= mem[s_adr[9:2]];
            end
        end else begin
            ram_ack <= 1'b0;
            ram_err <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    task automatic push(input int i, input logic [31:0] adr, input logic [31:0] dat,
                        input bit we, input int beats, input int gap);
        tq[i][tail[i]].adr   = adr;
        tq[i][tail[i]].dat   = dat;
        tq[i][tail[i]].we    = we;
        tq[i][tail[i]].beats = beats;
        tq[i][tail[i]].gap   = gap;
        tail[i]++;
    endtask

    task automatic drive_beat(input int i);
        txn_t t;
        t = tq[i][head[i]];
        m_adr[i*32 +: 32] = t.adr + 32'(4 * beat[i]);
        m_dat[i*32 +: 32] = t.dat + 32'(beat[i]);
        m_we[i]           = t.we;
        m_sel[i*4 +: 4]   = 4'hF;
        m_bte[i*2 +: 2]   = 2'b00;
        if (t.beats == 1)              m_cti[i*3 +: 3] = 3'b000;
        else if (beat[i] == t.beats-1) m_cti[i*3 +: 3] = 3'b111;
        else                           m_cti[i*3 +: 3] = 3'b010;
    endtask

    task automatic agent_step();
        for (int i = 0; i < N; i++) begin
            if (act[i]) begin
                if (ack_s[i] || err_s[i]) begin
                    beat[i]++;
                    if (beat[i] == tq[i][head[i]].beats) begin
                        m_cyc[i] = 1'b0;
                        m_stb[i] = 1'b0;
                        m_we[i]  = 1'b0;
                        act[i]   = 1'b0;
                        head[i]++;
                        wait_n[i] = 0;
                    end else begin
                        drive_beat(i);
                        m_stb[i] = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                end else if (!m_stb[i]) begin
                    m_stb[i] = 1'b1;
                end
            end else if (head[i] != tail[i]) begin
                if (wait_n[i] < tq[i][head[i]].gap) begin
                    wait_n[i]++;
                end else begin
                    act[i]  = 1'b1;
                    beat[i] = 0;
                    drive_beat(i);
                    m_cyc[i] = 1'b1;
                    m_stb[i] = 1'b1;
                end
            end
        end
    endtask

    // Ownership by the arbitration rules: rotate from the last winner, hold until cyc drops.
    task automatic model_step();
        if (rst_s) begin
            owner = -1;
            lastm = N - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (lastm + k) % N;
                if (owner < 0 && cyc_s[c]) begin
                    owner = c;
                    lastm = c;
                end
            end
        end else if (!cyc_s[owner]) begin
            owner = -1;
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] eg, ea, ee;
        logic [31:0]  eadr, edat;
        logic [9:0]   ereq;
        logic         ecyc, estb;
        int           idx;
        eg = '0; ea = '0; ee = '0; eadr = '0; edat = '0; ereq = '0; ecyc = 0; estb = 0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea[owner] = ram_ack;
            ee[owner] = ram_err;
            eadr = m_adr[owner*32 +: 32];
            edat = m_dat[owner*32 +: 32];
            ecyc = m_cyc[owner];
            estb = m_stb[owner];
            ereq = {m_we[owner], m_sel[owner*4 +: 4], m_cti[owner*3 +: 3], m_bte[owner*2 +: 2]};
        end
        chk("grant", grant, eg);
        chk("wbs_cyc", s_cyc, ecyc);
        chk("wbs_stb", s_stb, estb);
        chk("wbs_adr", s_adr, eadr);
        chk("wbs_dat", s_dat, edat);
        chk("wbs_ctl", {s_we, s_sel, s_cti, s_bte}, ereq);
        chk("ack", ack_o, ea);
        chk("err", err_o, ee);
        if (owner >= 0 && ram_ack) begin
            idx = int'(eadr[9:2]);
            if (m_we[owner]) begin
                shadow[idx] = edat;
                sh_vld[idx] = 1'b1;
            end else if (sh_vld[idx]) begin
                chk("rdata", dat_o, shadow[idx]);
            end
        end
    endtask

    task automatic log_cycle();
        for (int i = 0; i < N; i++) begin
            if (m_cyc[i] && !pcyc[i] && first_rise[i] < 0) first_rise[i] = ncyc;
            if (!m_cyc[i] && pcyc[i] && first_drop[i] < 0) first_drop[i] = ncyc;
            if (ack_o[i]) begin
                acks[i]++;
                if (!m_we[i]) rdata_last[i] = dat_o;
            end
        end
        if (grant != 0 && pgrant == 0 && g_n < 64) begin
            for (int j = 0; j < N; j++) if (grant[j]) g_order[g_n] = j;
            g_time[g_n] = ncyc;
            g_n++;
        end
        if (grant == 0 && pgrant != 0 && gfall < 0) gfall = ncyc;
        if (err_o != 0) begin
            err_seen   = err_o;
            ack_at_err = ack_o;
        end
        pcyc   = m_cyc;
        pgrant = grant;
    endtask

    task automatic clear_logs();
        g_n = 0; gfall = -1; err_seen = '0; ack_at_err = '0;
        for (int i = 0; i < N; i++) begin
            first_rise[i] = -1; first_drop[i] = -1; acks[i] = 0; rdata_last[i] = '0;
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = 1'b1;
        for (int i = 0; i < N; i++) if (head[i] != tail[i] || act[i] || m_cyc[i]) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n;
        bit idle;
        n = 0;
        idle = all_idle();
        while (!idle && n < budget) begin
            @(posedge clk); #2;
            idle = all_idle();
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk(tag, idle, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        clear_logs();
    endtask

    // Engine: check at negedge against the model, then advance model and agents after posedge.
    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        m_sel = '0; m_cti = '0; m_bte = '0;
        pcyc = '0; pgrant = '0; owner = -1; lastm = N - 1; ncyc = 0; jitter = 0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; act[i] = 0; wait_n[i] = 0; end
        for (int k = 0; k < 256; k++) sh_vld[k] = 1'b0;
        clear_logs();
        forever begin
            @(negedge clk);
            ncyc++;
            check_cycle();
            log_cycle();
            cyc_s = m_cyc; ack_s = ack_o; err_s = err_o; rst_s = rst;
            @(posedge clk); #1;
            model_step();
            agent_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total_beats;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, '0);
        chk("rst_cyc", s_cyc, 1'b0);
        chk("rst_ack", ack_o, '0);
        @(posedge clk); #2 rst = 1'b0;
        clear_logs();

        // single master write then read back
        push(0, 32'h10, 32'hDEADBEEF, 1'b1, 1, 0);
        push(0, 32'h10, 32'h0, 1'b0, 1, 3);
        wait_idle(200, "t1_idle");
        chk("t1_latency", g_time[0] - first_rise[0], 1);
        chk("t1_rdata", rdata_last[0], 32'hDEADBEEF);
        chk("t1_ack1", acks[1], 0);

        // simultaneous first request after reset
        do_reset();
        push(0, 32'h100, 32'h11111111, 1'b1, 1, 0);
        push(1, 32'h104, 32'h22222222, 1'b1, 1, 0);
        wait_idle(200, "t2_idle");
        chk("t2_ngrants", g_n, 2);
        chk("t2_first", g_order[0], 0);
        chk("t2_second", g_order[1], 1);
        chk("t2_latency", g_time[0] - first_rise[0], 1);
        chk("t2_handover", g_time[1] - first_drop[0], 2);
        chk("t2_idle_gap", g_time[1] - gfall, 1);

        // burst hold
        do_reset();
        push(1, 32'h20, 32'hB0B0_0000, 1'b1, 4, 0);
        push(0, 32'h30, 32'hC0C0_0000, 1'b1, 1, 2);
        push(0, 32'h2C, 32'h0, 1'b0, 1, 0);
        wait_idle(300, "t3_idle");
        chk("t3_ngrants", g_n, 3);
        chk("t3_first", g_order[0], 1);
        chk("t3_second", g_order[1], 0);
        chk("t3_acks1", acks[1], 4);
        chk("t3_acks0", acks[0], 2);
        chk("t3_rdata", rdata_last[0], 32'hB0B0_0003);

        // fairness
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++)
                push(i, 32'(32'h200 + 16 * i + 4 * r), $urandom, 1'b1, 1, 0);
        wait_idle(500, "t4_idle");
        chk("t4_ngrants", g_n, 12);
        for (int k = 0; k < 12; k++) chk("t4_order", g_order[k], k % N);
        for (int i = 0; i < N; i++) chk("t4_acks", acks[i], 4);

        // error routing
        do_reset();
        push(1, ERR_ADR, 32'h0, 1'b0, 1, 0);
        wait_idle(200, "t5_idle");
        chk("t5_err", err_seen, 3'b010);
        chk("t5_ack", ack_at_err, 3'b000);

        // reset in the middle of a burst
        do_reset();
        push(0, 32'h40, 32'hA5A5_0000, 1'b1, 4, 0);
        push(1, 32'h80, 32'h5A5A_5A5A, 1'b1, 1, 0);
        n = 0;
        while (!(act[0] && beat[0] == 1) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("t6_reach_beat2", beat[0], 1);
        clear_logs();
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_grant", grant, '0);
        chk("t6_cyc", s_cyc, 1'b0);
        wait_idle(300, "t6_idle");
        chk("t6_first", g_order[0], 0);

        // randomized traffic with stb jitter
        do_reset();
        jitter = 1;
        total_beats = 0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 12; k++) begin
                int b;
                b = $urandom_range(1, 4);
                total_beats += b;
                push(i, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                     1'($urandom_range(0, 1)), b, $urandom_range(0, 4));
            end
        end
        wait_idle(5000, "t7_idle");
        chk("t7_acks", acks[0] + acks[1] + acks[2], total_beats);
        jitter = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
